// File: rtl/bnn_pkg.sv
// Shared BNN definitions: neuron count, reset weight table, transmit FSM states
// and nibble-phase encoding, common to the core and the weight-stream transmitter.
package bnn_pkg;

  localparam int unsigned NUM_NEURONS = 12;
  localparam int unsigned WEIGHT_W    = 8;
  localparam int unsigned NIBBLE_W    = 4;
  localparam int unsigned TBL_IDX_W   = $clog2(NUM_NEURONS);

  // Index 0..11: layer-1 neurons 0..7, then layer-2 neurons 0..3.
  localparam logic [WEIGHT_W-1:0] RESET_WEIGHTS [NUM_NEURONS] = '{
    8'hA0, 8'h41, 8'h7A, 8'h18, 8'hED, 8'hB7,
    8'h67, 8'h3A, 8'hF9, 8'h62, 8'hF7, 8'h0F
  };

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LO   = 3'd1,
    ST_HI   = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } tx_state_e;

  typedef enum logic {
    PH_LO = 1'b0,
    PH_HI = 1'b1
  } nib_phase_e;

  // Entries beyond the shared table reset to zero.
  function automatic logic [WEIGHT_W-1:0] reset_weight(input int unsigned i);
    if (i < NUM_NEURONS) return RESET_WEIGHTS[TBL_IDX_W'(i)];
    return '0;
  endfunction

  function automatic logic [NIBBLE_W-1:0] nib_sel(input logic [WEIGHT_W-1:0] b,
                                                 input nib_phase_e ph);
    return (ph == PH_HI) ? b[7:4] : b[3:0];
  endfunction

endpackage

// File: rtl/bnn_weight_image.sv
// Local weight image: NUM_NEURONS x 8 register file with reset table,
// range-checked write port and combinational read.
module bnn_weight_image
  import bnn_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = bnn_pkg::NUM_NEURONS,
  parameter int unsigned ADDR_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_allow,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_idx,
  output logic [7:0]        rd_data_c,
  output logic              wr_reject_c
);

  localparam int unsigned IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  logic [7:0] img [NUM_NEURONS];
  logic       addr_ok;
  logic       rd_ok;
  logic       wr_do;

  assign addr_ok     = 32'(wr_addr) < NUM_NEURONS;
  assign rd_ok       = 32'(rd_idx) < NUM_NEURONS;
  assign wr_do       = wr_en && wr_allow && addr_ok;
  assign wr_reject_c = wr_en && !(wr_allow && addr_ok);
  assign rd_data_c   = rd_ok ? img[IDX_W'(rd_idx)] : 8'h00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
        img[IDX_W'(i)] <= reset_weight(i);
      end
    end else if (wr_do) begin
      img[IDX_W'(wr_addr)] <= wr_data;
    end
  end

endmodule

// File: rtl/bnn_weight_stream_tx.sv
// Transmit end of the BNN nibble-serial weight-loading bus: streams the local
// weight image low nibble first on load_en/nibble, advancing only when ena=1.
module bnn_weight_stream_tx
  import bnn_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = bnn_pkg::NUM_NEURONS,
  parameter int unsigned GAP_CYCLES  = 0,
  parameter int unsigned ADDR_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  input  logic              start,
  input  logic              abort,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic              load_en,
  output logic [3:0]        nibble,
  output logic              busy,
  output logic              done,
  output logic              wr_err
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_NEURONS - 1);

  tx_state_e         state, state_d;
  logic [ADDR_W-1:0] idx, idx_d, idx_inc, rd_idx;
  logic [GAP_W-1:0]  gap_cnt, gap_d;
  logic              abort_pend, abort_d, abort_hit;
  logic              load_en_d, busy_d, done_d;
  logic [3:0]        nibble_d;
  logic [7:0]        rd_data_c;
  logic              wr_reject_c;
  logic              wr_allow;
  logic              wr_fwd;

  assign idx_inc   = idx + ADDR_W'(1);
  assign abort_hit = abort_pend || abort;
  assign wr_allow  = (state == ST_IDLE) || (state == ST_DONE);
  // A write landing on entry 0 together with start must reach the first nibble.
  assign wr_fwd    = wr_en && (wr_addr == '0);
  assign rd_idx    = (state == ST_HI || state == ST_GAP) ? idx_inc :
                     (state == ST_LO) ? idx : '0;

  bnn_weight_image #(
    .NUM_NEURONS (NUM_NEURONS),
    .ADDR_W      (ADDR_W)
  ) u_image (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_allow    (wr_allow),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_idx      (rd_idx),
    .rd_data_c   (rd_data_c),
    .wr_reject_c (wr_reject_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      gap_cnt    <= '0;
      abort_pend <= 1'b0;
      load_en    <= 1'b0;
      nibble     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wr_err     <= 1'b0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      gap_cnt    <= gap_d;
      abort_pend <= abort_d;
      load_en    <= load_en_d;
      nibble     <= nibble_d;
      busy       <= busy_d;
      done       <= done_d;
      wr_err     <= wr_reject_c;
    end
  end

  // Outputs are decoded from the next state so they line up with it after the edge.
  always_comb begin
    state_d   = state;
    idx_d     = idx;
    gap_d     = gap_cnt;
    abort_d   = abort_pend || (abort && state != ST_IDLE);
    load_en_d = load_en;
    nibble_d  = nibble;
    busy_d    = busy;
    done_d    = done;

    unique case (state)
      ST_IDLE: begin
        load_en_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        if (start && ena) begin
          state_d   = ST_LO;
          idx_d     = '0;
          load_en_d = 1'b1;
          busy_d    = 1'b1;
          nibble_d  = nib_sel(wr_fwd ? wr_data : rd_data_c, PH_LO);
        end
      end
      ST_LO: begin
        if (ena) begin
          state_d  = ST_HI;
          nibble_d = nib_sel(rd_data_c, PH_HI);
        end
      end
      ST_HI: begin
        if (ena) begin
          if (idx == IDX_LAST) begin
            state_d   = ST_DONE;
            load_en_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
          end else if (abort_hit) begin
            state_d   = ST_IDLE;
            load_en_d = 1'b0;
            busy_d    = 1'b0;
            abort_d   = 1'b0;
          end else if (GAP_CYCLES > 0) begin
            state_d   = ST_GAP;
            gap_d     = '0;
            load_en_d = 1'b0;
          end else begin
            state_d  = ST_LO;
            idx_d    = idx_inc;
            nibble_d = nib_sel(rd_data_c, PH_LO);
          end
        end
      end
      ST_GAP: begin
        if (ena) begin
          if (gap_cnt == GAP_LAST) begin
            gap_d = '0;
            if (abort_hit) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              abort_d = 1'b0;
            end else begin
              state_d   = ST_LO;
              idx_d     = idx_inc;
              load_en_d = 1'b1;
              nibble_d  = nib_sel(rd_data_c, PH_LO);
            end
          end else begin
            gap_d = gap_cnt + GAP_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (ena) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
          abort_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        load_en_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bnn_weight_stream_tx.sv
// Directed bench for bnn_weight_stream_tx with a behavioural nibble receiver
// comparing captured bytes against an expected-byte queue.
module tb_bnn_weight_stream_tx;

  localparam int unsigned NN = 12;

  logic       clk = 1'b0;
  logic       reset, ena, start, abort, wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       load_en, busy, done, wr_err;
  logic [3:0] nibble;

  logic       start2;
  logic       zero1 = 1'b0;
  logic [3:0] zero4 = 4'h0;
  logic [7:0] zero8 = 8'h00;
  logic       load_en2, busy2, done2, wr_err2;
  logic [3:0] nibble2;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mimg [NN];
  logic [7:0] rst_tbl [NN] = '{8'hA0, 8'h41, 8'h7A, 8'h18, 8'hED, 8'hB7,
                               8'h67, 8'h3A, 8'hF9, 8'h62, 8'hF7, 8'h0F};
  logic [7:0] exp_q [$];
  logic       rx_phase = 1'b0;
  logic [3:0] rx_lo    = 4'h0;
  int         rx_bytes = 0;
  int         base;

  always #5 clk = ~clk;

  bnn_weight_stream_tx #(.NUM_NEURONS(12), .GAP_CYCLES(0), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .ena(ena), .start(start), .abort(abort),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .load_en(load_en), .nibble(nibble), .busy(busy), .done(done), .wr_err(wr_err)
  );

  bnn_weight_stream_tx #(.NUM_NEURONS(12), .GAP_CYCLES(2), .ADDR_W(4)) dut_gap (
    .clk(clk), .reset(reset), .ena(ena), .start(start2), .abort(zero1),
    .wr_en(zero1), .wr_addr(zero4), .wr_data(zero8),
    .load_en(load_en2), .nibble(nibble2), .busy(busy2), .done(done2), .wr_err(wr_err2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Receiver: captures what the DUT presents at the coming rising edge.
  always @(negedge clk) begin
    if (reset) begin
      rx_phase = 1'b0;
    end else if (ena && load_en) begin
      if (!rx_phase) begin
        rx_lo = nibble;
      end else begin
        rx_bytes++;
        chk("rx_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("rx_byte", {24'h0, nibble, rx_lo}, {24'h0, exp_q.pop_front()});
      end
      rx_phase = ~rx_phase;
    end
  end

  task automatic start_frame(input int nbytes);
    for (int i = 0; i < nbytes; i++) exp_q.push_back(mimg[4'(i)]);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Called in cycle 1 of a frame; optional 3-cycle ena stall at cycle stall_at.
  task automatic run_frame(input int stall_at);
    logic [7:0] b;
    logic [3:0] en;
    for (int c = 1; c <= 2 * NN; c++) begin
      b  = mimg[4'((c - 1) / 2)];
      en = (c % 2 == 1) ? b[3:0] : b[7:4];
      chk("frame_load_en", 32'(load_en), 32'd1);
      chk("frame_nibble", 32'(nibble), 32'(en));
      chk("frame_busy", 32'(busy), 32'd1);
      chk("frame_no_early_done", 32'(done), 32'd0);
      if (c == stall_at) begin
        ena = 1'b0;
        repeat (3) begin
          step();
          chk("stall_nibble", 32'(nibble), 32'(en));
          chk("stall_load_en", 32'(load_en), 32'd1);
          chk("stall_done", 32'(done), 32'd0);
        end
        ena = 1'b1;
      end
      step();
    end
    chk("frame_done", 32'(done), 32'd1);
    chk("frame_done_busy", 32'(busy), 32'd0);
    chk("frame_done_load_en", 32'(load_en), 32'd0);
    step();
    chk("frame_done_pulse_end", 32'(done), 32'd0);
    chk("frame_idle_busy", 32'(busy), 32'd0);
    chk("frame_q_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1; ena = 1'b1; start = 1'b0; abort = 1'b0; start2 = 1'b0;
    wr_en = 1'b0; wr_addr = 4'h0; wr_data = 8'h00;
    for (int i = 0; i < NN; i++) mimg[4'(i)] = rst_tbl[4'(i)];
    #2;
    chk("rst_load_en", 32'(load_en), 32'd0);
    chk("rst_nibble", 32'(nibble), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wr_err", 32'(wr_err), 32'd0);
    step(); step();
    reset = 1'b0;
    step();

    // Frame from reset image
    base = rx_bytes;
    start_frame(NN);
    run_frame(0);
    chk("frame1_bytes", 32'(rx_bytes - base), 32'd12);

    // Write entry 0 together with start: first byte must be the new value
    mimg[0] = 8'h5C;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h5C;
    start_frame(NN);
    wr_en = 1'b0;
    chk("fwd_wr_err", 32'(wr_err), 32'd0);
    run_frame(0);

    // ena stall during HI of neuron 4 (cycle 10)
    base = rx_bytes;
    start_frame(NN);
    run_frame(10);
    chk("stall_bytes", 32'(rx_bytes - base), 32'd12);

    // Rejected write while busy, then abort during LO of neuron 2
    base = rx_bytes;
    start_frame(3);
    step(); step();
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'hFF;
    step();
    chk("busy_wr_err", 32'(wr_err), 32'd1);
    wr_en = 1'b0;
    step();
    chk("busy_wr_err_clear", 32'(wr_err), 32'd0);
    chk("abort_lo_nibble", 32'(nibble), 32'h0A);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_hi_nibble", 32'(nibble), 32'h07);
    chk("abort_hi_load_en", 32'(load_en), 32'd1);
    step();
    chk("abort_load_en", 32'(load_en), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_no_done", 32'(done), 32'd0);
    step();
    chk("abort_still_idle", 32'(load_en), 32'd0);
    chk("abort_no_done_late", 32'(done), 32'd0);
    chk("abort_bytes", 32'(rx_bytes - base), 32'd3);
    chk("abort_q_empty", 32'(exp_q.size()), 32'd0);

    // Out-of-range write in IDLE
    wr_en = 1'b1; wr_addr = 4'd12; wr_data = 8'h33;
    step();
    chk("range_wr_err", 32'(wr_err), 32'd1);
    wr_en = 1'b0;
    step();
    chk("range_wr_err_clear", 32'(wr_err), 32'd0);

    // Abort in IDLE ignored; start with abort: start wins, full frame, image intact
    abort = 1'b1;
    step();
    chk("idle_abort_busy", 32'(busy), 32'd0);
    start_frame(NN);
    abort = 1'b0;
    run_frame(0);

    // Gap build: 2 idle cycles between bytes, done on cycle 47
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int c = 1; c <= 46; c++) begin
      chk("gap_load_en", 32'(load_en2), 32'(((c - 1) % 4) < 2));
      chk("gap_busy", 32'(busy2), 32'd1);
      step();
    end
    chk("gap_done", 32'(done2), 32'd1);
    chk("gap_done_busy", 32'(busy2), 32'd0);
    step();
    chk("gap_done_end", 32'(done2), 32'd0);

    // Reset mid-frame drops load_en asynchronously
    start_frame(0);
    chk("midrst_pre_load_en", 32'(load_en), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_load_en", 32'(load_en), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    step();
    reset = 1'b0;
    step();
    chk("midrst_idle", 32'(load_en), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bnn_weight_stream_tx.md
Name: bnn_weight_stream_tx

Overview:
- Transmit end of the BNN nibble-serial weight-loading interface.
- Holds a local image of all neuron weight bytes and, on start, streams them to the BNN core over the load_en + 4-bit nibble bus, low nibble first.
- Sits on the driving side of the core's uio weight pins: load_en maps to uio[3], nibble maps to uio[7:4].

Parameters:
- NUM_NEURONS, 12, number of 8-bit weight entries per frame (8 layer-1 + 4 layer-2).
- GAP_CYCLES, 0, idle cycles with load_en low inserted between neurons (0 = back-to-back).
- ADDR_W, 4, width of wr_addr; must satisfy 2**ADDR_W >= NUM_NEURONS.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- ena  in  1  shared enable; the receiver samples only when ena=1, so the transmitter advances only when ena=1
- start  in  1  request one full frame; honoured only in IDLE
- abort  in  1  request early stop; takes effect at the next neuron boundary
- wr_en  in  1  write one weight byte into the local image
- wr_addr  in  ADDR_W  neuron index for the write
- wr_data  in  8  weight byte, bit 0 = weight for input bit 0
- load_en  out  1  drives receiver load enable
- nibble  out  4  drives receiver weight nibble
- busy  out  1  high from the first load cycle until return to IDLE
- done  out  1  one-cycle pulse on successful frame completion
- wr_err  out  1  one-cycle pulse on a rejected write

Behaviour:
- Reset (asynchronous):
  - state=IDLE, load_en=0, nibble=0, busy=0, done=0, wr_err=0, neuron index=0, gap counter=0.
  - Image resets to the core's reset weights: A0,41,7A,18,ED,B7,67,3A,F9,62,F7,0F (hex, index 0..11).
- All outputs are registered.
- FSM states: IDLE, LO, HI, GAP, DONE.
- IDLE:
  - start=1 and ena=1 -> LO next cycle with idx=0.
  - start is ignored when ena=0.
- LO:
  - load_en=1, nibble=img[idx][3:0].
  - ena=1 -> HI at the next edge, because the receiver captures the low nibble on that edge.
- HI:
  - load_en=1, nibble=img[idx][7:4].
  - ena=1 -> byte complete. Then:
    - idx==NUM_NEURONS-1 -> DONE.
    - else, abort pending -> IDLE, with no done pulse.
    - else GAP_CYCLES>0 -> GAP.
    - else -> LO with idx+1.
- GAP:
  - load_en=0, nibble holds its last value.
  - Counts GAP_CYCLES ena-qualified cycles, then -> LO with idx+1, or -> IDLE if abort is pending.
- DONE:
  - load_en=0, done=1 for exactly one cycle, busy=0, then -> IDLE.
- ena=0 in any non-IDLE state:
  - State, idx and outputs freeze.
  - load_en may stay high; the receiver ignores it while ena=0.
- Latency: start edge to first nibble is 1 cycle; the full frame takes 2*NUM_NEURONS + (NUM_NEURONS-1)*GAP_CYCLES ena-cycles, followed by the DONE cycle.
- abort:
  - Sticky until honoured or until return to IDLE.
  - Never splits a byte, so the receiver's nibble phase stays aligned.
  - abort during IDLE is ignored.
- start while busy is ignored (no queueing).
- Writes:
  - In IDLE or DONE, wr_en writes img[wr_addr]=wr_data at the edge.
  - In LO/HI/GAP, wr_en is rejected: image unchanged, wr_err pulses.
  - wr_addr >= NUM_NEURONS is rejected in any state with a wr_err pulse.
- Simultaneous start and wr_en in IDLE: the write lands first, and the frame transmits the new value.
- Simultaneous start and abort in IDLE: start wins and abort is cleared.
- Reset mid-frame: load_en drops immediately (asynchronously). The receiver must be reset with it to clear its nibble phase; system reset is shared.

Decomposition:
- Shared package bnn_pkg:
  - NUM_NEURONS and the 8-bit weight reset-value constant array, shared with the BNN core so both ends reset to identical weights.
  - State enum for the FSM above.
  - Nibble-phase encoding: 0 = low nibble, 1 = high nibble.
- One natural sub-module: bnn_weight_image. It holds the NUM_NEURONS x 8 register file with reset values, the write port with range check, and a combinational read by idx.
- The FSM, counters and output registers stay in bnn_weight_stream_tx.

Test Plan:
- Reset defaults, ena=1, pulse start:
  - Cycles 1..4 show load_en=1 with nibble 0,A,1,4.
  - The 24th nibble is 0.
  - done pulses once on cycle 25, then busy=0.
  - A behavioural receiver captures 12 bytes equal to the reset table.
- Write in IDLE, wr_addr=0, wr_data=5C, then start -> first two nibbles are C then 5; the remaining stream is unchanged.
- Drive ena=0 for 3 cycles while in HI of neuron 4 -> nibble stays E, state frozen. After ena returns: receiver byte 4 = ED, and total frame length = 24 ena-cycles.
- Assert abort during LO of neuron 2 -> HI of neuron 2 still sent (nibble 7); load_en=0 on the next cycle; busy=0; no done pulse; receiver holds 3 complete bytes.
- wr_en while busy (wr_addr=3) and wr_en with wr_addr=12 in IDLE -> wr_err pulses each time and the image is unchanged.
- GAP_CYCLES=2 build -> exactly 2 load_en=0 cycles between each byte pair; done on cycle 47.
